game_flow_controller: RTL and testbench

Parametrised round/level sequencer for the pinball game. It replaces the fixed 4-bit controller with configurable score, life and level widths, a level-weighted saturating score, per-level hit targets, a player pause and an explicit win state. It consumes the collision and key strobes from the object/collision layer and drives pause, reset_level and the score/level/life counters consumed by the HUD and the object movers.

---
 rtl/game_flow_controller.sv | 163 ++++++++++++++++
 tb/tb_game_flow_controller.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/game_flow_controller.sv
// Round/level sequencer: serve, play, pause, game-over and win, with level-weighted saturating score.
// Optional GAME_BONUS_LIFE_EN: clearing a level also awards one life (saturating at LIFE_MAX).
module game_flow_controller #(
  parameter int SCORE_W        = 8,
  parameter int LEVEL_W        = 4,
  parameter int LIFE_W         = 4,
  parameter int LIFE_INIT      = 3,
  parameter int LIFE_MAX       = 9,
  parameter int LEVEL_MAX      = 5,
  parameter int HITS_PER_LEVEL = 4
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               key_start,
  input  logic               key_pause,
  input  logic               collision_bottom,
  input  logic               collision_target,
  output logic               pause,
  output logic               reset_level,
  output logic [SCORE_W-1:0] score,
  output logic [LEVEL_W-1:0] level,
  output logic [LIFE_W-1:0]  life,
  output logic [7:0]         hits,
  output logic               game_over,
  output logic               game_won
);

  typedef enum logic [2:0] {
    S_SERVE  = 3'd0,
    S_PLAY   = 3'd1,
    S_PAUSED = 3'd2,
    S_OVER   = 3'd3,
    S_WIN    = 3'd4
  } state_t;

  localparam int SUM_W = ((SCORE_W > LEVEL_W) ? SCORE_W : LEVEL_W) + 1;
  localparam logic [SUM_W-1:0]   SCORE_SAT   = SUM_W'({SCORE_W{1'b1}});
  localparam logic [LIFE_W-1:0]  LIFE_RST    = LIFE_W'(LIFE_INIT);
  localparam logic [LEVEL_W-1:0] LEVEL_LAST  = LEVEL_W'(LEVEL_MAX - 1);
  localparam logic [7:0]         HITS_TARGET = 8'(HITS_PER_LEVEL);

  // Bit order of the event vector: {start, pause, bottom, target}
  logic [3:0]         w_in;
  logic [3:0]         r_prev;
  logic [3:0]         r_evt;
  state_t             r_state, w_state_nxt;
  logic [SCORE_W-1:0] r_score, w_score_nxt;
  logic [LEVEL_W-1:0] r_level, w_level_nxt;
  logic [LIFE_W-1:0]  r_life, w_life_nxt;
  logic [7:0]         r_hits, w_hits_nxt;
  logic [7:0]         w_hits_inc;
  logic [SUM_W-1:0]   w_sum;
  logic [LIFE_W-1:0]  w_life_bonus;

  assign w_in = {key_start, key_pause, collision_bottom, collision_target};

  // Edge detectors register the event pulse so the FSM acts one edge after sampling
  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_prev <= 4'b0000;
      r_evt  <= 4'b0000;
    end else begin
      r_prev <= w_in;
      r_evt  <= w_in & ~r_prev;
    end
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_state <= S_SERVE;
      r_score <= '0;
      r_level <= '0;
      r_life  <= LIFE_RST;
      r_hits  <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_score <= w_score_nxt;
      r_level <= w_level_nxt;
      r_life  <= w_life_nxt;
      r_hits  <= w_hits_nxt;
    end
  end

  assign w_sum      = SUM_W'(r_score) + SUM_W'(r_level) + SUM_W'(1);
  assign w_hits_inc = r_hits + 8'd1;

`ifdef GAME_BONUS_LIFE_EN
  assign w_life_bonus = (r_life < LIFE_W'(LIFE_MAX)) ? (r_life + LIFE_W'(1)) : r_life;
`else
  assign w_life_bonus = r_life;
`endif

  // Next-state and counter update logic
  always_comb begin
    w_state_nxt = r_state;
    w_score_nxt = r_score;
    w_level_nxt = r_level;
    w_life_nxt  = r_life;
    w_hits_nxt  = r_hits;
    case (r_state)
      S_SERVE: begin
        w_hits_nxt = 8'd0;
        if (r_evt[3]) w_state_nxt = S_PLAY;
        else          w_state_nxt = S_SERVE;
      end
      S_PLAY: begin
        if (r_evt[1]) begin
          w_hits_nxt = 8'd0;
          if (r_life != '0) w_life_nxt = r_life - LIFE_W'(1);
          else              w_life_nxt = r_life;
          if (r_life <= LIFE_W'(1)) w_state_nxt = S_OVER;
          else                      w_state_nxt = S_SERVE;
        end else if (r_evt[0]) begin
          if (w_sum > SCORE_SAT) w_score_nxt = SCORE_SAT[SCORE_W-1:0];
          else                   w_score_nxt = w_sum[SCORE_W-1:0];
          if (w_hits_inc == HITS_TARGET) begin
            w_hits_nxt = 8'd0;
            w_life_nxt = w_life_bonus;
            if (r_level >= LEVEL_LAST) begin
              w_state_nxt = S_WIN;
            end else begin
              w_level_nxt = r_level + LEVEL_W'(1);
              w_state_nxt = S_SERVE;
            end
          end else begin
            w_hits_nxt = w_hits_inc;
          end
        end else if (r_evt[2]) begin
          w_state_nxt = S_PAUSED;
        end else begin
          w_state_nxt = S_PLAY;
        end
      end
      S_PAUSED: begin
        if (r_evt[2]) w_state_nxt = S_PLAY;
        else          w_state_nxt = S_PAUSED;
      end
      S_OVER, S_WIN: begin
        if (r_evt[3]) begin
          w_score_nxt = '0;
          w_level_nxt = '0;
          w_life_nxt  = LIFE_RST;
          w_hits_nxt  = 8'd0;
          w_state_nxt = S_SERVE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: w_state_nxt = S_SERVE;
    endcase
  end

  assign pause       = (r_state != S_PLAY);
  assign reset_level = (r_state == S_SERVE);
  assign game_over   = (r_state == S_OVER);
  assign game_won    = (r_state == S_WIN);
  assign score       = r_score;
  assign level       = r_level;
  assign life        = r_life;
  assign hits        = r_hits;

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed bench for game_flow_controller: default-parameter vector table plus
// hand sequences for held inputs, reset corners, score saturation and the win state.
module tb_game_flow_controller;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic key_start = 1'b0, key_pause = 1'b0, collision_bottom = 1'b0, collision_target = 1'b0;

  logic       pause_d, rl_d, over_d, won_d;
  logic [7:0] score_d, hits_d;
  logic [3:0] level_d, life_d;

  logic       pause_s, rl_s, over_s, won_s;
  logic [3:0] score_s, level_s, life_s;
  logic [7:0] hits_s;

  logic       pause_w, rl_w, over_w, won_w;
  logic [7:0] score_w, hits_w;
  logic [3:0] level_w, life_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  game_flow_controller dut (
    .clk(clk), .resetN(resetN), .key_start(key_start), .key_pause(key_pause),
    .collision_bottom(collision_bottom), .collision_target(collision_target),
    .pause(pause_d), .reset_level(rl_d), .score(score_d), .level(level_d),
    .life(life_d), .hits(hits_d), .game_over(over_d), .game_won(won_d)
  );

  game_flow_controller #(.SCORE_W(4)) dut_sat (
    .clk(clk), .resetN(resetN), .key_start(key_start), .key_pause(key_pause),
    .collision_bottom(collision_bottom), .collision_target(collision_target),
    .pause(pause_s), .reset_level(rl_s), .score(score_s), .level(level_s),
    .life(life_s), .hits(hits_s), .game_over(over_s), .game_won(won_s)
  );

  game_flow_controller #(.LEVEL_MAX(2)) dut_win (
    .clk(clk), .resetN(resetN), .key_start(key_start), .key_pause(key_pause),
    .collision_bottom(collision_bottom), .collision_target(collision_target),
    .pause(pause_w), .reset_level(rl_w), .score(score_w), .level(level_w),
    .life(life_w), .hits(hits_w), .game_over(over_w), .game_won(won_w)
  );

  typedef struct {
    logic s, p, b, t;
    int   score, level, life, hits;
    logic pause, rl, over, won;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(logic s, logic p, logic b, logic t,
                              int sc, int lv, int lf, int ht,
                              logic pa, logic rl, logic ov, logic wn);
    vec_t v;
    v.s = s; v.p = p; v.b = b; v.t = t;
    v.score = sc; v.level = lv; v.life = lf; v.hits = ht;
    v.pause = pa; v.rl = rl; v.over = ov; v.won = wn;
    return v;
  endfunction

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_main(input string tag, input int sc, input int lv, input int lf,
                            input int ht, input int pa, input int rl, input int ov, input int wn);
    cmp({tag, ".score"}, int'(score_d), sc);
    cmp({tag, ".level"}, int'(level_d), lv);
    cmp({tag, ".life"}, int'(life_d), lf);
    cmp({tag, ".hits"}, int'(hits_d), ht);
    cmp({tag, ".pause"}, int'(pause_d), pa);
    cmp({tag, ".reset_level"}, int'(rl_d), rl);
    cmp({tag, ".game_over"}, int'(over_d), ov);
    cmp({tag, ".game_won"}, int'(won_d), wn);
  endtask

  // One-cycle input pulse; returns at the negedge after the FSM has acted on it
  task automatic pulse(input logic s, input logic p, input logic b, input logic t);
    @(negedge clk);
    key_start = s; key_pause = p; collision_bottom = b; collision_target = t;
    @(negedge clk);
    key_start = 1'b0; key_pause = 1'b0; collision_bottom = 1'b0; collision_target = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetN = 1'b0;
    repeat (2) @(negedge clk);
    resetN = 1'b1;
  endtask

  initial begin
    tbl[0]  = mk(1,0,0,0, 0,0,3,0, 0,0,0,0);
    tbl[1]  = mk(0,0,0,1, 1,0,3,1, 0,0,0,0);
    tbl[2]  = mk(0,0,0,1, 2,0,3,2, 0,0,0,0);
    tbl[3]  = mk(0,0,0,1, 3,0,3,3, 0,0,0,0);
    tbl[4]  = mk(0,0,0,1, 4,1,3,0, 1,1,0,0);
    tbl[5]  = mk(1,0,0,0, 4,1,3,0, 0,0,0,0);
    tbl[6]  = mk(0,0,0,1, 6,1,3,1, 0,0,0,0);
    tbl[7]  = mk(0,1,0,0, 6,1,3,1, 1,0,0,0);
    tbl[8]  = mk(0,0,0,1, 6,1,3,1, 1,0,0,0);
    tbl[9]  = mk(0,0,1,0, 6,1,3,1, 1,0,0,0);
    tbl[10] = mk(0,1,0,0, 6,1,3,1, 0,0,0,0);
    tbl[11] = mk(0,0,1,1, 6,1,2,0, 1,1,0,0);
    tbl[12] = mk(1,0,0,0, 6,1,2,0, 0,0,0,0);
    tbl[13] = mk(0,0,1,0, 6,1,1,0, 1,1,0,0);
    tbl[14] = mk(1,0,0,0, 6,1,1,0, 0,0,0,0);
    tbl[15] = mk(0,0,1,0, 6,1,0,0, 1,0,1,0);
    tbl[16] = mk(0,0,0,1, 6,1,0,0, 1,0,1,0);
    tbl[17] = mk(1,0,0,0, 0,0,3,0, 1,1,0,0);

    do_reset();
    @(negedge clk);
    check_main("reset", 0,0,3,0, 1,1,0,0);

    for (int i = 0; i < 18; i++) begin
      pulse(tbl[i].s, tbl[i].p, tbl[i].b, tbl[i].t);
      check_main($sformatf("vec%0d", i), tbl[i].score, tbl[i].level, tbl[i].life,
                 tbl[i].hits, tbl[i].pause, tbl[i].rl, tbl[i].over, tbl[i].won);
    end

    // Held collision counts once
    do_reset();
    pulse(1,0,0,0);
    @(negedge clk);
    collision_target = 1'b1;
    repeat (10) @(negedge clk);
    collision_target = 1'b0;
    repeat (2) @(negedge clk);
    check_main("held_target", 1,0,3,1, 0,0,0,0);

    // Pause toggling, then reset while paused
    pulse(0,1,0,0);
    cmp("pause_on", int'(pause_d), 1);
    pulse(0,0,1,1);
    check_main("paused_ignore", 1,0,3,1, 1,0,0,0);
    pulse(0,1,0,0);
    cmp("pause_off", int'(pause_d), 0);
    pulse(0,1,0,0);
    cmp("pause_again", int'(pause_d), 1);
    @(negedge clk);
    resetN = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
    check_main("reset_paused", 0,0,3,0, 1,1,0,0);

    // Start key held through reset release yields one start edge
    @(negedge clk);
    key_start = 1'b1;
    resetN = 1'b0;
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    cmp("held_start_serve", int'(pause_d), 1);
    repeat (2) @(negedge clk);
    cmp("held_start_play", int'(pause_d), 0);
    key_start = 1'b0;

    // Saturation (SCORE_W=4) and win (LEVEL_MAX=2) share the same stimulus
    do_reset();
    pulse(1,0,0,0);
    repeat (4) pulse(0,0,0,1);
    pulse(1,0,0,0);
    repeat (4) pulse(0,0,0,1);
    cmp("win.game_won", int'(won_w), 1);
    cmp("win.pause", int'(pause_w), 1);
    cmp("win.score", int'(score_w), 12);
    cmp("win.level", int'(level_w), 1);
    cmp("win.hits", int'(hits_w), 0);
    cmp("sat.pre_score", int'(score_s), 12);
    cmp("sat.pre_level", int'(level_s), 2);
    pulse(0,0,0,1);
    pulse(0,0,1,0);
    cmp("win_hold.score", int'(score_w), 12);
    cmp("win_hold.life", int'(life_w), 3);
    cmp("win_hold.game_won", int'(won_w), 1);
    cmp("win_hold.game_over", int'(over_w), 0);
    pulse(1,0,0,0);
    cmp("win_restart.game_won", int'(won_w), 0);
    cmp("win_restart.score", int'(score_w), 0);
    cmp("win_restart.level", int'(level_w), 0);
    cmp("win_restart.reset_level", int'(rl_w), 1);
    pulse(0,0,0,1);
    cmp("sat.score", int'(score_s), 15);
    cmp("sat.hits", int'(hits_s), 1);
    cmp("win_serve.hits", int'(hits_w), 0);
    pulse(0,0,0,1);
    cmp("sat.score2", int'(score_s), 15);
    cmp("sat.hits2", int'(hits_s), 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
